// File: rtl/hall_input_filter.sv
// hall_input_filter: conditions the raw hall sensor pins for the BLDC peripheral.
// Synchroniser -> glitch filter (candidate + run counter) -> acceptance with
// invalid-code rejection and multi-bit step detection, plus a saturating error counter.
// Optional stall detector enabled by defining HALL_FILTER_STALL_EN; when undefined,
// stall is tied low and no stall counter exists.
module hall_input_filter #(
  parameter int unsigned filter_cycles = 16,
  parameter int unsigned sync_stages   = 2,
  parameter int unsigned err_cnt_width = 16,
  parameter int unsigned stall_cycles  = 54_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               hall_raw,
  input  logic                     err_clear,
  output logic [2:0]               hall_out,
  output logic                     hall_valid,
  output logic                     change_stb,
  output logic                     invalid_code,
  output logic                     illegal_step,
  output logic [err_cnt_width-1:0] err_count,
  output logic                     stall
);

  localparam int unsigned cnt_w = $clog2(filter_cycles + 1);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(filter_cycles);

  // Elaboration-time sanity checks on the configuration.
  if (filter_cycles < 1) begin : g_chk_filter
    $error("hall_input_filter: filter_cycles must be >= 1");
  end
  if (sync_stages < 2) begin : g_chk_sync
    $error("hall_input_filter: sync_stages must be >= 2");
  end
  if (err_cnt_width < 1) begin : g_chk_err
    $error("hall_input_filter: err_cnt_width must be >= 1");
  end
  if (stall_cycles < 1) begin : g_chk_stall
    $error("hall_input_filter: stall_cycles must be >= 1");
  end

  // True when a code change flips more than one of the three hall bits.
  function automatic logic multi_bit(input logic [2:0] d);
    return (d[0] & d[1]) | (d[1] & d[2]) | (d[0] & d[2]);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [err_cnt_width-1:0] sat_inc(input logic [err_cnt_width-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]       sync_q [sync_stages];
  logic [2:0]       s;
  logic [2:0]       candidate;
  logic [cnt_w-1:0] cnt;
  logic [cnt_w-1:0] cnt_next;
  logic             same;
  logic             accept;
  logic             code_bad;
  logic             step_bad;
  logic             err_inc;

  // Metastability synchroniser on the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(sync_stages); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hall_raw;
      for (int i = 1; i < int'(sync_stages); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[sync_stages-1];

  // Run-length filter and acceptance decision. Acceptance happens on the edge
  // where the run counter reaches filter_cycles, so it fires once per run; a
  // counter already sitting at saturation does not fire again.
  always_comb begin
    same     = (s == candidate);
    cnt_next = 1;
    if (same) cnt_next = (cnt == cnt_max) ? cnt : cnt + 1'b1;
    accept   = (cnt_next == cnt_max) && !(same && (cnt == cnt_max)) && (s != hall_out);
    code_bad = (s == 3'b000) || (s == 3'b111);
    step_bad = hall_valid && multi_bit(s ^ hall_out);
    err_inc  = accept && (code_bad || step_bad);
  end

  // Candidate register and run counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      cnt       <= '0;
    end else begin
      candidate <= s;
      cnt       <= cnt_next;
    end
  end

  // Accepted code, validity flag and registered event pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_out     <= '0;
      hall_valid   <= 1'b0;
      change_stb   <= 1'b0;
      invalid_code <= 1'b0;
      illegal_step <= 1'b0;
    end else begin
      change_stb   <= 1'b0;
      invalid_code <= 1'b0;
      illegal_step <= 1'b0;
      if (accept) begin
        if (code_bad) begin
          invalid_code <= 1'b1;
        end else begin
          hall_out     <= s;
          hall_valid   <= 1'b1;
          change_stb   <= 1'b1;
          // Still accepted so the encoder resynchronises to the new position.
          illegal_step <= step_bad;
        end
      end
    end
  end

  // Saturating diagnostic counter; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err_count <= '0;
    else if (err_clear) err_count <= '0;
    else if (err_inc)   err_count <= sat_inc(err_count);
  end

`ifdef HALL_FILTER_STALL_EN
  localparam int unsigned stall_w = $clog2(stall_cycles + 1);
  localparam logic [stall_w-1:0] stall_max = stall_w'(stall_cycles);

  logic [stall_w-1:0] stall_cnt;

  // Time since the last accepted change; held at the limit once reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                stall_cnt <= '0;
    else if (change_stb)                         stall_cnt <= '0;
    else if (hall_valid && stall_cnt != stall_max) stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall = (stall_cnt == stall_max);
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_hall_input_filter.sv
// Directed testbench for hall_input_filter (filter_cycles=16, sync_stages=2,
// err_cnt_width=2 so saturation is reachable, stall_cycles=100).
module tb_hall_input_filter;

  logic       clk;
  logic       reset_n;
  logic [2:0] hall_raw;
  logic       err_clear;
  logic [2:0] hall_out;
  logic       hall_valid;
  logic       change_stb;
  logic       invalid_code;
  logic       illegal_step;
  logic [1:0] err_count;
  logic       stall;

  int checks = 0;
  int passed = 0;
  int n_stb = 0;
  int n_inv = 0;
  int n_ill = 0;
  int n_stall = 0;

  hall_input_filter #(
    .filter_cycles(16),
    .sync_stages(2),
    .err_cnt_width(2),
    .stall_cycles(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hall_raw(hall_raw),
    .err_clear(err_clear),
    .hall_out(hall_out),
    .hall_valid(hall_valid),
    .change_stb(change_stb),
    .invalid_code(invalid_code),
    .illegal_step(illegal_step),
    .err_count(err_count),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (change_stb)   n_stb++;
      if (invalid_code) n_inv++;
      if (illegal_step) n_ill++;
      if (stall)        n_stall++;
    end
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hall_raw = 3'b010; err_clear = 1'b0;
    step(3);
    checks++; if (hall_out !== 3'b000) $display("FAIL rst_hall_out: got %b want 000", hall_out); else passed++;
    checks++; if (hall_valid !== 1'b0) $display("FAIL rst_hall_valid: got %b want 0", hall_valid); else passed++;
    checks++; if (err_count !== 2'd0) $display("FAIL rst_err_count: got %0d want 0", err_count); else passed++;
    checks++; if ({change_stb, invalid_code, illegal_step, stall} !== 4'b0) $display("FAIL rst_pulses: got %b want 0000", {change_stb, invalid_code, illegal_step, stall}); else passed++;
    hall_raw = 3'b000;
    reset_n = 1'b1;
    step(25);
    checks++; if (n_stb + n_inv + n_ill !== 0) $display("FAIL idle_000_events: got %0d want 0", n_stb + n_inv + n_ill); else passed++;
    checks++; if (hall_valid !== 1'b0) $display("FAIL idle_hall_valid: got %b want 0", hall_valid); else passed++;
  endtask

  task automatic test_first_code();
    int b_stb;
    b_stb = n_stb;
    hall_raw = 3'b001;
    step(17);
    checks++; if (hall_out !== 3'b000) $display("FAIL t1_early: got %b want 000", hall_out); else passed++;
    step(1);
    checks++; if (hall_out !== 3'b001) $display("FAIL t1_hall_out: got %b want 001", hall_out); else passed++;
    checks++; if (change_stb !== 1'b1) $display("FAIL t1_change_stb: got %b want 1", change_stb); else passed++;
    checks++; if (hall_valid !== 1'b1) $display("FAIL t1_hall_valid: got %b want 1", hall_valid); else passed++;
    checks++; if (illegal_step !== 1'b0) $display("FAIL t1_illegal: got %b want 0", illegal_step); else passed++;
    step(20);
    checks++; if (n_stb - b_stb !== 1) $display("FAIL t1_stb_count: got %0d want 1", n_stb - b_stb); else passed++;
  endtask

  task automatic test_glitch();
    int b_ev;
    b_ev = n_stb + n_inv + n_ill;
    hall_raw = 3'b011;
    step(15);
    hall_raw = 3'b001;
    step(30);
    checks++; if (hall_out !== 3'b001) $display("FAIL t2_hall_out: got %b want 001", hall_out); else passed++;
    checks++; if (n_stb + n_inv + n_ill - b_ev !== 0) $display("FAIL t2_events: got %0d want 0", n_stb + n_inv + n_ill - b_ev); else passed++;
  endtask

  task automatic test_invalid_code();
    int b_inv, b_stb;
    b_inv = n_inv; b_stb = n_stb;
    hall_raw = 3'b111;
    step(17);
    checks++; if (err_count !== 2'd0) $display("FAIL t3_err_early: got %0d want 0", err_count); else passed++;
    step(1);
    checks++; if (invalid_code !== 1'b1) $display("FAIL t3_invalid_code: got %b want 1", invalid_code); else passed++;
    checks++; if (err_count !== 2'd1) $display("FAIL t3_err_count: got %0d want 1", err_count); else passed++;
    step(22);
    hall_raw = 3'b001;
    step(30);
    checks++; if (hall_out !== 3'b001) $display("FAIL t3_hall_out: got %b want 001", hall_out); else passed++;
    checks++; if (n_inv - b_inv !== 1) $display("FAIL t3_inv_count: got %0d want 1", n_inv - b_inv); else passed++;
    checks++; if (n_stb - b_stb !== 0) $display("FAIL t3_bounce_stb: got %0d want 0", n_stb - b_stb); else passed++;
  endtask

  task automatic test_illegal_step();
    hall_raw = 3'b110;
    step(18);
    checks++; if (hall_out !== 3'b110) $display("FAIL t4_hall_out: got %b want 110", hall_out); else passed++;
    checks++; if ({change_stb, illegal_step} !== 2'b11) $display("FAIL t4_pulses: got %b want 11", {change_stb, illegal_step}); else passed++;
    checks++; if (err_count !== 2'd2) $display("FAIL t4_err_count: got %0d want 2", err_count); else passed++;
    step(1);
    checks++; if (illegal_step !== 1'b0) $display("FAIL t4_pulse_width: got %b want 0", illegal_step); else passed++;
    // 110 -> 101 is a 2-bit step; clear lands on the increment edge.
    hall_raw = 3'b101;
    step(17);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    checks++; if (illegal_step !== 1'b1) $display("FAIL t4_clr_illegal: got %b want 1", illegal_step); else passed++;
    checks++; if (err_count !== 2'd0) $display("FAIL t4_clear_wins: got %0d want 0", err_count); else passed++;
  endtask

  task automatic test_err_saturation();
    logic [2:0] codes [4];
    logic [1:0] exp_err [4];
    codes = '{3'b010, 3'b101, 3'b010, 3'b101};
    exp_err = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      hall_raw = codes[i];
      step(20);
      checks++; if (err_count !== exp_err[i]) $display("FAIL sat_err_%0d: got %0d want %0d", i, err_count, exp_err[i]); else passed++;
    end
    checks++; if (hall_out !== 3'b101) $display("FAIL sat_hall_out: got %b want 101", hall_out); else passed++;
  endtask

  task automatic test_reset_mid_run();
    hall_raw = 3'b001;
    step(20);
    checks++; if (hall_out !== 3'b001) $display("FAIL t5_pre: got %b want 001", hall_out); else passed++;
    hall_raw = 3'b011;
    step(8);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({hall_out, hall_valid, err_count} !== 6'b0) $display("FAIL t5_async_clear: got %b want 000000", {hall_out, hall_valid, err_count}); else passed++;
    step(1);
    reset_n = 1'b1;
    step(17);
    checks++; if (hall_out !== 3'b000) $display("FAIL t5_early: got %b want 000", hall_out); else passed++;
    step(1);
    checks++; if (hall_out !== 3'b011) $display("FAIL t5_hall_out: got %b want 011", hall_out); else passed++;
    checks++; if ({change_stb, illegal_step} !== 2'b10) $display("FAIL t5_pulses: got %b want 10", {change_stb, illegal_step}); else passed++;
    checks++; if (err_count !== 2'd0) $display("FAIL t5_err_count: got %0d want 0", err_count); else passed++;
  endtask

`ifdef HALL_FILTER_STALL_EN
  task automatic test_stall();
    step(100);
    checks++; if (stall !== 1'b0) $display("FAIL t6_stall_early: got %b want 0", stall); else passed++;
    step(1);
    checks++; if (stall !== 1'b1) $display("FAIL t6_stall_set: got %b want 1", stall); else passed++;
    hall_raw = 3'b010;
    step(18);
    checks++; if ({change_stb, stall} !== 2'b11) $display("FAIL t6_stall_hold: got %b want 11", {change_stb, stall}); else passed++;
    step(1);
    checks++; if (stall !== 1'b0) $display("FAIL t6_stall_clear: got %b want 0", stall); else passed++;
  endtask
`else
  task automatic test_stall();
    step(150);
    checks++; if (stall !== 1'b0) $display("FAIL t6_stall_tied: got %b want 0", stall); else passed++;
    checks++; if (n_stall !== 0) $display("FAIL t6_stall_seen: got %0d want 0", n_stall); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_first_code();
    test_glitch();
    test_invalid_code();
    test_illegal_step();
    test_err_saturation();
    test_reset_mid_run();
    test_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
